// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom/address pipeline: zoom mode encodings
// and default geometry (320x240 source image, 10-bit coordinates).
package zoom_pkg;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;
    localparam int DEF_CW    = 10;
    localparam int DEF_AW    = 17;

    localparam logic [2:0] ZM_NORMAL = 3'b000;
    localparam logic [2:0] ZM_IN2    = 3'b001;
    localparam logic [2:0] ZM_IN4    = 3'b010;
    localparam logic [2:0] ZM_OUT2   = 3'b011;
    localparam logic [2:0] ZM_OUT4   = 3'b100;

endpackage

// File: rtl/zoom_scale.sv
// Combinational scale + pan for one axis. The result is three bits wider
// than the coordinate so that a 4x zoom-out plus a full pan cannot wrap.
module zoom_scale
    import zoom_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic [CW-1:0] v,
    input  logic [2:0]    mode,
    input  logic [CW-1:0] pan,
    output logic [CW+2:0] s
);

    logic [CW+2:0] v_ext;
    logic [CW+2:0] scaled;

    assign v_ext = {3'b000, v};

    // Select the scaling for the mode; reserved codes behave as normal.
    always_comb begin
        scaled = v_ext;
        case (mode)
            ZM_IN2:  scaled = v_ext >> 1;
            ZM_IN4:  scaled = v_ext >> 2;
            ZM_OUT2: scaled = v_ext << 1;
            ZM_OUT4: scaled = v_ext << 2;
            default: scaled = v_ext;
        endcase
        s = scaled + {3'b000, pan};
    end

endmodule

// File: rtl/zoom_addr_pipe.sv
// Three-stage zoom/address pipeline between the VGA timing generator and
// the frame-buffer read port.
//   S1: scale + pan, S2: range check (+ optional mirror) and row multiply,
//   S3: column add, out-of-range zeroing, output registers.
// Optional horizontal mirroring is enabled with ZOOM_ADDR_MIRROR_EN.
//
// Handshake: in_valid qualifies next_x/next_y for one cycle; there is no
// ready (the pipe always accepts). out_valid is in_valid delayed by three
// cycles and qualifies img_x/img_y/address/in_range; when it is low those
// outputs hold their previous values.
module zoom_addr_pipe
    import zoom_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int CW    = DEF_CW,
    parameter int AW    = DEF_AW,
    parameter int CNTW  = 17
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            frame_start,
    input  logic            in_valid,
    input  logic [CW-1:0]   next_x,
    input  logic [CW-1:0]   next_y,
    input  logic [2:0]      zoom_sel,
    input  logic [CW-1:0]   pan_x,
    input  logic [CW-1:0]   pan_y,
`ifdef ZOOM_ADDR_MIRROR_EN
    input  logic            mirror_x,
`endif
    output logic            out_valid,
    output logic [CW-1:0]   img_x,
    output logic [CW-1:0]   img_y,
    output logic [AW-1:0]   address,
    output logic            in_range,
    output logic [CNTW-1:0] oor_count
);

    localparam logic [CW+2:0] IMG_W_X  = (CW+3)'(IMG_W);
    localparam logic [CW+2:0] IMG_H_X  = (CW+3)'(IMG_H);
    localparam logic [CW+2:0] IMG_W_M1 = (CW+3)'(IMG_W - 1);
    localparam logic [AW-1:0] IMG_W_A  = AW'(IMG_W);

    // ---------------- shadow settings ----------------
    logic [2:0]    sh_zoom;
    logic [CW-1:0] sh_pan_x;
    logic [CW-1:0] sh_pan_y;
    logic [2:0]    eff_zoom;
    logic [CW-1:0] eff_pan_x;
    logic [CW-1:0] eff_pan_y;
    logic          eff_mirror;

`ifdef ZOOM_ADDR_MIRROR_EN
    logic sh_mirror;
`endif

    // Capture requested settings only at frame boundaries.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sh_zoom   <= ZM_NORMAL;
            sh_pan_x  <= '0;
            sh_pan_y  <= '0;
`ifdef ZOOM_ADDR_MIRROR_EN
            sh_mirror <= 1'b0;
`endif
        end else if (frame_start) begin
            sh_zoom   <= zoom_sel;
            sh_pan_x  <= pan_x;
            sh_pan_y  <= pan_y;
`ifdef ZOOM_ADDR_MIRROR_EN
            sh_mirror <= mirror_x;
`endif
        end
    end

    // A pixel arriving with frame_start already sees the new settings.
    assign eff_zoom  = frame_start ? zoom_sel : sh_zoom;
    assign eff_pan_x = frame_start ? pan_x    : sh_pan_x;
    assign eff_pan_y = frame_start ? pan_y    : sh_pan_y;
`ifdef ZOOM_ADDR_MIRROR_EN
    assign eff_mirror = frame_start ? mirror_x : sh_mirror;
`else
    assign eff_mirror = 1'b0;
`endif

    // ---------------- S1: scale and pan ----------------
    logic [CW+2:0] sx_c;
    logic [CW+2:0] sy_c;

    zoom_scale #(.CW(CW)) u_scale_x (
        .v    (next_x),
        .mode (eff_zoom),
        .pan  (eff_pan_x),
        .s    (sx_c)
    );

    zoom_scale #(.CW(CW)) u_scale_y (
        .v    (next_y),
        .mode (eff_zoom),
        .pan  (eff_pan_y),
        .s    (sy_c)
    );

    logic          s1_valid;
    logic [CW+2:0] s1_sx;
    logic [CW+2:0] s1_sy;
    logic          s1_mirror;

    // Register the unwrapped source coordinates.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sx     <= '0;
            s1_sy     <= '0;
            s1_mirror <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sx     <= sx_c;
                s1_sy     <= sy_c;
                s1_mirror <= eff_mirror;
            end
        end
    end

    // ---------------- S2: range check, mirror, row multiply ----------------
    logic          s2_inr_c;
    logic [CW+2:0] s2_sx_c;
    logic [AW-1:0] s2_row_c;

    assign s2_inr_c = (s1_sx < IMG_W_X) && (s1_sy < IMG_H_X);
    // Mirroring only applies to in-range pixels, so it never underflows.
    assign s2_sx_c  = (s1_mirror && s2_inr_c) ? (IMG_W_M1 - s1_sx) : s1_sx;
    assign s2_row_c = {{(AW-CW){1'b0}}, s1_sy[CW-1:0]} * IMG_W_A;

    logic          s2_valid;
    logic          s2_inr;
    logic [CW-1:0] s2_x;
    logic [CW-1:0] s2_y;
    logic [AW-1:0] s2_row;

    // Register truncated coordinates, row base and range flag.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_inr   <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_row   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inr <= s2_inr_c;
                s2_x   <= s2_sx_c[CW-1:0];
                s2_y   <= s1_sy[CW-1:0];
                s2_row <= s2_row_c;
            end
        end
    end

    // ---------------- S3: address add, zeroing, outputs ----------------
    // Output registers update only for valid pixels, otherwise they hold.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            img_x     <= '0;
            img_y     <= '0;
            address   <= '0;
            in_range  <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                if (s2_inr) begin
                    img_x    <= s2_x;
                    img_y    <= s2_y;
                    address  <= s2_row + {{(AW-CW){1'b0}}, s2_x};
                    in_range <= 1'b1;
                end else begin
                    img_x    <= '0;
                    img_y    <= '0;
                    address  <= '0;
                    in_range <= 1'b0;
                end
            end
        end
    end

    // ---------------- out-of-range counter ----------------
    logic [CNTW-1:0] run_cnt;
    logic [CNTW-1:0] run_cnt_next;
    logic            oor_inc;

    assign oor_inc      = s2_valid && !s2_inr;
    assign run_cnt_next = (oor_inc && (run_cnt != {CNTW{1'b1}})) ?
                          run_cnt + CNTW'(1) : run_cnt;

    // Count out-of-range results; publish and clear at each frame start.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt   <= '0;
            oor_count <= '0;
        end else if (frame_start) begin
            oor_count <= run_cnt_next;
            run_cnt   <= '0;
        end else begin
            run_cnt <= run_cnt_next;
        end
    end

endmodule

// File: tb/tb_zoom_addr_pipe.sv
// Testbench for zoom_addr_pipe: directed cases followed by random traffic,
// checked through an expected queue against a coordinate-level model.
// Define ZOOM_ADDR_MIRROR_EN to exercise the mirror option.
module tb_zoom_addr_pipe;

    localparam int IMG_W = 320;
    localparam int IMG_H = 240;
    localparam int CW    = 10;
    localparam int AW    = 17;
    localparam int CNTW  = 17;
    localparam int W     = CW + CW + AW + 1;

    // ---------------- clock / reset ----------------
    logic            clk_in = 1'b0;
    logic            rst_n;
    logic            frame_start;
    logic            in_valid;
    logic [CW-1:0]   next_x;
    logic [CW-1:0]   next_y;
    logic [2:0]      zoom_sel;
    logic [CW-1:0]   pan_x;
    logic [CW-1:0]   pan_y;
    logic            mirror_x;
    logic            out_valid;
    logic [CW-1:0]   img_x;
    logic [CW-1:0]   img_y;
    logic [AW-1:0]   address;
    logic            in_range;
    logic [CNTW-1:0] oor_count;

    always #5 clk_in = ~clk_in;

    zoom_addr_pipe #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .AW(AW), .CNTW(CNTW)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .next_x      (next_x),
        .next_y      (next_y),
        .zoom_sel    (zoom_sel),
        .pan_x       (pan_x),
        .pan_y       (pan_y),
`ifdef ZOOM_ADDR_MIRROR_EN
        .mirror_x    (mirror_x),
`endif
        .out_valid   (out_valid),
        .img_x       (img_x),
        .img_y       (img_y),
        .address     (address),
        .in_range    (in_range),
        .oor_count   (oor_count)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int ev_q[$];           // clock-edge index at which each out-of-range pixel is counted
    int cyc = 0;

    int req_zoom = 0, req_px = 0, req_py = 0;
    bit req_mir = 1'b0;
    int sh_zoom = 0, sh_px = 0, sh_py = 0;
    bit sh_mir = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: zoom by plain multiply/divide, pan, bounds, optional mirror.
    function automatic logic [W-1:0] ref_model(input int x, input int y, input int mode,
                                               input int px, input int py, input bit mir);
        int fx, fy, sx, sy;
        case (mode)
            1: begin fx = x / 2; fy = y / 2; end
            2: begin fx = x / 4; fy = y / 4; end
            3: begin fx = x * 2; fy = y * 2; end
            4: begin fx = x * 4; fy = y * 4; end
            default: begin fx = x; fy = y; end
        endcase
        sx = fx + px;
        sy = fy + py;
        if (sx < IMG_W && sy < IMG_H) begin
            if (mir) sx = IMG_W - 1 - sx;
            return {CW'(sx), CW'(sy), AW'(sy * IMG_W + sx), 1'b1};
        end
        return '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit fs, input bit v, input int x, input int y);
        logic [W-1:0] e;
        bit mir_eff;
        int n;
        frame_start = fs;
        in_valid    = v;
        next_x      = CW'(x);
        next_y      = CW'(y);
        zoom_sel    = 3'(req_zoom);
        pan_x       = CW'(req_px);
        pan_y       = CW'(req_py);
        mirror_x    = req_mir;
        if (fs) begin
            sh_zoom = req_zoom; sh_px = req_px; sh_py = req_py; sh_mir = req_mir;
        end
`ifdef ZOOM_ADDR_MIRROR_EN
        mir_eff = sh_mir;
`else
        mir_eff = 1'b0;
`endif
        if (v) begin
            e = ref_model(x, y, sh_zoom, sh_px, sh_py, mir_eff);
            exp_q.push_back(e);
            if (!e[0]) ev_q.push_back(cyc + 3);
        end
        @(posedge clk_in);
        cyc++;
        #1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        if (fs) begin
            n = 0;
            while (ev_q.size() > 0 && ev_q[0] <= cyc) begin
                void'(ev_q.pop_front());
                n++;
            end
            check("oor_count", 64'(oor_count), 64'(n));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        exp_q.delete();
        ev_q.delete();
        sh_zoom = 0; sh_px = 0; sh_py = 0; sh_mir = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_img_x", 64'(img_x), 64'd0);
        check("rst_img_y", 64'(img_y), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_in_range", 64'(in_range), 64'd0);
        check("rst_oor_count", 64'(oor_count), 64'd0);
        repeat (hold) @(posedge clk_in);
        cyc += hold;
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        rst_n       = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] last_out = '0;
    always @(negedge clk_in) begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        got = {img_x, img_y, address, in_range};
        if (!rst_n) begin
            last_out = '0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%0h required=none t=%0t", got, $time);
            end else begin
                e = exp_q.pop_front();
                check("pixel", 64'(got), 64'(e));
            end
            last_out = got;
        end else begin
            check("hold", 64'(got), 64'(last_out));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1; frame_start = 1'b0; in_valid = 1'b0;
        next_x = '0; next_y = '0; zoom_sel = '0; pan_x = '0; pan_y = '0; mirror_x = 1'b0;
        #2;
        do_reset(3);

        // normal mode, no pan
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 10, 20);
        idle(4);

        // zoom-in 2x, then zoom-out 4x (out of range)
        req_zoom = 1; step(1'b1, 1'b1, 100, 50);
        req_zoom = 4; step(1'b1, 1'b1, 100, 50);
        idle(3);

        // pan at the image corner
        req_zoom = 0; req_px = 10; req_py = 5;
        step(1'b1, 1'b1, 309, 234);
        step(1'b0, 1'b1, 310, 234);
        idle(3);

        // mid-frame change ignored, then applied with a same-cycle pixel
        req_zoom = 2; req_px = 0; req_py = 0;
        step(1'b0, 1'b1, 100, 50);
        step(1'b1, 1'b1, 100, 50);
        idle(4);

        // seven out-of-range pixels in one frame
        req_zoom = 4;
        step(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 200 + i, 100);
        idle(4);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);

`ifdef ZOOM_ADDR_MIRROR_EN
        req_zoom = 0; req_mir = 1'b1;
        step(1'b1, 1'b1, 10, 20);
        idle(3);
        req_mir = 1'b0;
        step(1'b1, 1'b0, 0, 0);
`endif

        // reset with pixels in flight
        req_zoom = 0;
        step(1'b1, 1'b1, 1, 1);
        step(1'b0, 1'b1, 2, 2);
        in_valid = 1'b1; next_x = 10'd3; next_y = 10'd3;
        do_reset(2);
        idle(5);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                req_zoom = $urandom_range(0, 7);
                req_px   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
                req_py   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
                req_mir  = 1'($urandom_range(0, 1));
            end
            step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 639), $urandom_range(0, 479));
        end
        idle(6);
        step(1'b1, 1'b0, 0, 0);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
